// File: rtl/mc_main_fsm.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath controls.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   opcode, funct    IR[31:26] and IR[5:0]
//   mem_ready        memory finished the current access this cycle
//   IorD .. BranchNe datapath enables and mux selects (see per-state decode)
//   illegal_op       unsupported opcode seen in DECODE
//   state            current state register, for debug
module mc_main_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ImmZero,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       BranchNe,
    output logic       illegal_op,
    output logic [3:0] state
);

    // Opcode/funct encodings, identical to the shared cpu.svh definitions.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] F_JR     = 6'b001000;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        IMMEXEC  = 4'd9,
        IMMWB    = 4'd10,
        JUMP     = 4'd11,
        JR       = 4'd12
    } state_t;

    state_t st;

    logic is_rtype;
    logic is_mem;
    logic is_jr;
    logic is_alu;
    logic is_br;
    logic is_imm;
    logic is_j;
    logic is_zext;
    logic is_legal;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_jr    = is_rtype && (funct == F_JR);
    assign is_alu   = is_rtype && (funct != F_JR);
    assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI)
                   || (opcode == OP_XORI);
    assign is_imm   = is_zext || (opcode == OP_ADDI)
                   || (opcode == OP_SLTI);
    assign is_j     = (opcode == OP_J);
    assign is_legal = is_mem || is_rtype || is_br || is_imm || is_j;

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= FETCH;
        end else begin
            case (st)
                FETCH:    if (mem_ready) st <= DECODE;
                DECODE: begin
                    unique case (1'b1)
                        is_mem:  st <= MEMADR;
                        is_jr:   st <= JR;
                        is_alu:  st <= EXECUTE;
                        is_br:   st <= BRANCH;
                        is_imm:  st <= IMMEXEC;
                        is_j:    st <= JUMP;
                        default: st <= FETCH;
                    endcase
                end
                MEMADR: begin
                    if (opcode == OP_LW)      st <= MEMREAD;
                    else if (opcode == OP_SW) st <= MEMWRITE;
                    else                      st <= FETCH;
                end
                MEMREAD:  if (mem_ready) st <= MEMWB;
                MEMWRITE: if (mem_ready) st <= FETCH;
                EXECUTE:  st <= ALUWB;
                IMMEXEC:  st <= IMMWB;
                default:  st <= FETCH;
            endcase
        end
    end

    // Outputs follow the state register; the only input terms are the
    // FETCH handshake, the DECODE legality check and opcode-qualified
    // flags. Reset overrides everything with non-writing FETCH values,
    // which suppresses any writeback in the reset cycle itself.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ImmZero    = 1'b0;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        illegal_op = 1'b0;
        if (rst) begin
            ALUSrcB = 2'b01;
        end else begin
            case (st)
                FETCH: begin
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = ~is_legal;
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMREAD: begin
                    IorD = 1'b1;
                end
                MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMWRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 2'b01;
                    PCSrc    = 2'b01;
                    Branch   = (opcode == OP_BEQ);
                    BranchNe = (opcode == OP_BNE);
                end
                IMMEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ImmZero = is_zext;
                end
                IMMWB: begin
                    RegWrite = 1'b1;
                    ImmZero  = is_zext;
                end
                JUMP: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
                JR: begin
                    PCSrc   = 2'b11;
                    PCWrite = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm.
// Each cycle pushes the expected state and control word, then pops and compares.
module tb_mc_main_fsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] F_JR     = 6'b001000;
    localparam logic [5:0] F_ADD    = 6'b100000;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzero;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       ctl;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ImmZero;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCWrite;
    logic       Branch;
    logic       BranchNe;
    logic       illegal_op;
    logic [3:0] state;

    int checks;
    int errors;
    exp_t sb[$];

    mc_main_fsm dut (
        .clk(clk),
        .rst(rst),
        .opcode(opcode),
        .funct(funct),
        .mem_ready(mem_ready),
        .IorD(IorD),
        .MemWrite(MemWrite),
        .IRWrite(IRWrite),
        .RegDst(RegDst),
        .MemtoReg(MemtoReg),
        .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ImmZero(ImmZero),
        .ALUOp(ALUOp),
        .PCSrc(PCSrc),
        .PCWrite(PCWrite),
        .Branch(Branch),
        .BranchNe(BranchNe),
        .illegal_op(illegal_op),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word required in state s for the given inputs.
    function automatic ctl_t spec_ctl(input logic [3:0] s, input logic [5:0] op,
                                      input logic mr, input logic r);
        ctl_t c;
        logic zext;
        logic legal;
        c = '0;
        zext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE)
             || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI)
             || (op == OP_SLTI) || zext || (op == OP_J);
        if (r) begin
            c.alusrcb = 2'b01;
            return c;
        end
        case (s)
            4'd0: begin c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
            4'd1: begin c.alusrcb = 2'b11; c.illegal = ~legal; end
            4'd2: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            4'd3: begin c.iord = 1'b1; end
            4'd4: begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            4'd5: begin c.iord = 1'b1; c.memwrite = 1'b1; end
            4'd6: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            4'd7: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            4'd8: begin
                c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
                c.branch = (op == OP_BEQ); c.branchne = (op == OP_BNE);
            end
            4'd9: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.immzero = zext; end
            4'd10: begin c.regwrite = 1'b1; c.immzero = zext; end
            4'd11: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            4'd12: begin c.pcsrc = 2'b11; c.pcwrite = 1'b1; end
            default: begin end
        endcase
        return c;
    endfunction

    // One clock cycle: drive inputs, push expectation, compare mid-cycle.
    task automatic cyc(input logic mr, input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic [3:0] est,
                       input string name);
        exp_t e;
        exp_t g;
        ctl_t act;
        mem_ready = mr;
        rst = r;
        opcode = op;
        funct = fn;
        e.st = est;
        e.ctl = spec_ctl(est, op, mr, r);
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ImmZero, ALUOp, PCSrc, PCWrite, Branch, BranchNe,
               illegal_op};
        checks++;
        if (state !== g.st) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", g.name, state, g.st);
        end
        checks++;
        if (act !== g.ctl) begin
            errors++;
            $display("FAIL %s ctl (st %0d): got %b expected %b",
                     g.name, g.st, act, g.ctl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 1, OP_LW, 6'd0, 4'd0, "reset_hold");
        cyc(1, 1, OP_LW, 6'd0, 4'd0, "reset_hold2");
        cyc(0, 0, OP_LW, 6'd0, 4'd0, "reset_release");
    endtask

    task automatic test_lw();
        cyc(1, 0, OP_LW, 6'd0, 4'd0, "lw_fetch");
        cyc(1, 0, OP_LW, 6'd0, 4'd1, "lw_decode");
        cyc(1, 0, OP_LW, 6'd0, 4'd2, "lw_memadr");
        cyc(1, 0, OP_LW, 6'd0, 4'd3, "lw_memread");
        cyc(1, 0, OP_LW, 6'd0, 4'd4, "lw_memwb");
        cyc(0, 0, OP_LW, 6'd0, 4'd0, "lw_done");
    endtask

    task automatic test_sw_stall();
        cyc(1, 0, OP_SW, 6'd0, 4'd0, "sw_fetch");
        cyc(1, 0, OP_SW, 6'd0, 4'd1, "sw_decode");
        cyc(1, 0, OP_SW, 6'd0, 4'd2, "sw_memadr");
        cyc(0, 0, OP_SW, 6'd0, 4'd5, "sw_stall1");
        cyc(0, 0, OP_SW, 6'd0, 4'd5, "sw_stall2");
        cyc(1, 0, OP_SW, 6'd0, 4'd5, "sw_write");
        cyc(0, 0, OP_SW, 6'd0, 4'd0, "sw_done");
    endtask

    task automatic test_lw_stall();
        cyc(1, 0, OP_LW, 6'd0, 4'd0, "lws_fetch");
        cyc(0, 0, OP_LW, 6'd0, 4'd1, "lws_decode");
        cyc(0, 0, OP_LW, 6'd0, 4'd2, "lws_memadr");
        cyc(0, 0, OP_LW, 6'd0, 4'd3, "lws_stall");
        cyc(1, 0, OP_LW, 6'd0, 4'd3, "lws_read");
        cyc(0, 0, OP_LW, 6'd0, 4'd4, "lws_memwb");
        cyc(0, 0, OP_LW, 6'd0, 4'd0, "lws_done");
    endtask

    task automatic test_rtype_jr();
        cyc(1, 0, OP_RTYPE, F_ADD, 4'd0, "add_fetch");
        cyc(1, 0, OP_RTYPE, F_ADD, 4'd1, "add_decode");
        cyc(1, 0, OP_RTYPE, F_ADD, 4'd6, "add_execute");
        cyc(1, 0, OP_RTYPE, F_ADD, 4'd7, "add_aluwb");
        cyc(0, 0, OP_RTYPE, F_ADD, 4'd0, "add_done");
        cyc(1, 0, OP_RTYPE, F_JR, 4'd0, "jr_fetch");
        cyc(1, 0, OP_RTYPE, F_JR, 4'd1, "jr_decode");
        cyc(1, 0, OP_RTYPE, F_JR, 4'd12, "jr_jr");
        cyc(0, 0, OP_RTYPE, F_JR, 4'd0, "jr_done");
    endtask

    task automatic test_branch_imm();
        cyc(1, 0, OP_BEQ, 6'd0, 4'd0, "beq_fetch");
        cyc(1, 0, OP_BEQ, 6'd0, 4'd1, "beq_decode");
        cyc(1, 0, OP_BEQ, 6'd0, 4'd8, "beq_branch");
        cyc(0, 0, OP_BEQ, 6'd0, 4'd0, "beq_done");
        cyc(1, 0, OP_BNE, 6'd0, 4'd0, "bne_fetch");
        cyc(1, 0, OP_BNE, 6'd0, 4'd1, "bne_decode");
        cyc(1, 0, OP_BNE, 6'd0, 4'd8, "bne_branch");
        cyc(0, 0, OP_BNE, 6'd0, 4'd0, "bne_done");
        cyc(1, 0, OP_ANDI, 6'd0, 4'd0, "andi_fetch");
        cyc(1, 0, OP_ANDI, 6'd0, 4'd1, "andi_decode");
        cyc(1, 0, OP_ANDI, 6'd0, 4'd9, "andi_exec");
        cyc(1, 0, OP_ANDI, 6'd0, 4'd10, "andi_wb");
        cyc(0, 0, OP_ANDI, 6'd0, 4'd0, "andi_done");
        cyc(1, 0, OP_ADDI, 6'd0, 4'd0, "addi_fetch");
        cyc(1, 0, OP_ADDI, 6'd0, 4'd1, "addi_decode");
        cyc(1, 0, OP_ADDI, 6'd0, 4'd9, "addi_exec");
        cyc(1, 0, OP_ADDI, 6'd0, 4'd10, "addi_wb");
        cyc(0, 0, OP_ADDI, 6'd0, 4'd0, "addi_done");
    endtask

    task automatic test_fetch_stall_illegal();
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 6'b111111, 6'd0, 4'd0, "ill_fetch_stall");
        cyc(1, 0, 6'b111111, 6'd0, 4'd0, "ill_fetch");
        cyc(1, 0, 6'b111111, 6'd0, 4'd1, "ill_decode");
        cyc(0, 0, 6'b111111, 6'd0, 4'd0, "ill_after");
        cyc(0, 0, 6'b111111, 6'd0, 4'd0, "ill_after2");
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, OP_LW, 6'd0, 4'd0, "rmid_fetch");
        cyc(1, 0, OP_LW, 6'd0, 4'd1, "rmid_decode");
        cyc(1, 0, OP_LW, 6'd0, 4'd2, "rmid_memadr");
        cyc(1, 0, OP_LW, 6'd0, 4'd3, "rmid_memread");
        cyc(1, 1, OP_LW, 6'd0, 4'd4, "rmid_memwb_rst");
        cyc(1, 1, OP_LW, 6'd0, 4'd0, "rmid_rst_held");
        cyc(0, 0, OP_LW, 6'd0, 4'd0, "rmid_released");
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, OP_ORI, 6'd0, 4'd0, "b2b_ori_fetch");
        cyc(0, 0, OP_ORI, 6'd0, 4'd1, "b2b_ori_decode");
        cyc(0, 0, OP_ORI, 6'd0, 4'd9, "b2b_ori_exec");
        cyc(0, 0, OP_ORI, 6'd0, 4'd10, "b2b_ori_wb");
        cyc(1, 0, OP_ORI, 6'd0, 4'd0, "b2b_j_fetch");
        cyc(0, 0, OP_J, 6'd0, 4'd1, "b2b_j_decode");
        cyc(0, 0, OP_J, 6'd0, 4'd11, "b2b_j_jump");
        cyc(1, 0, OP_J, 6'd0, 4'd0, "b2b_slti_fetch");
        cyc(1, 0, OP_SLTI, 6'd0, 4'd1, "b2b_slti_decode");
        cyc(1, 0, OP_SLTI, 6'd0, 4'd9, "b2b_slti_exec");
        cyc(1, 0, OP_SLTI, 6'd0, 4'd10, "b2b_slti_wb");
        cyc(1, 0, OP_XORI, 6'd0, 4'd0, "b2b_xori_fetch");
        cyc(1, 0, OP_XORI, 6'd0, 4'd1, "b2b_xori_decode");
        cyc(1, 0, OP_XORI, 6'd0, 4'd9, "b2b_xori_exec");
        cyc(1, 0, OP_XORI, 6'd0, 4'd10, "b2b_xori_wb");
        cyc(0, 0, OP_XORI, 6'd0, 4'd0, "b2b_done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        opcode = OP_LW;
        funct = 6'd0;
        mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_lw_stall();
        test_rtype_jr();
        test_branch_imm();
        test_fetch_stall_illegal();
        test_reset_mid();
        test_back_to_back();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
